// File: rtl/serializer_rr_scheduler.sv
// Round-robin scheduler/sequencer for a shared MSB-first PISO serializer.
// Grants one requester word at a time, issues the parallel load, counts the
// shift cycles, flags valid output bits and enforces an idle gap between frames.
module serializer_rr_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    ser_load,
  output logic [WIDTH-1:0]        ser_data,
  output logic                    ser_bit_valid,
  output logic                    frame_start,
  output logic                    frame_done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int unsigned IDW      = $clog2(NREQ);
  localparam int unsigned CW       = $clog2(WIDTH + 16);
  localparam int unsigned LAST_BIT = WIDTH - 1;
  localparam int unsigned LAST_GAP = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    count;

  logic             found_c;
  logic [IDW-1:0]   winner_c;
  logic [WIDTH-1:0] win_word_c;
  logic             accept_c;

  // Round-robin pick: first valid index at/after rr_ptr, then wrap to the low indices
  always_comb begin
    found_c    = 1'b0;
    winner_c   = '0;
    win_word_c = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_c && req_valid[k] && (IDW'(k) >= rr_ptr)) begin
        found_c  = 1'b1;
        winner_c = IDW'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found_c && req_valid[k]) begin
        found_c  = 1'b1;
        winner_c = IDW'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == winner_c) begin
        win_word_c = req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot ready toward the winner, only while idle, enabled and out of reset
  always_comb begin
    accept_c  = rst_n && (state == IDLE) && enable && found_c;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = accept_c && (IDW'(k) == winner_c);
    end
  end

  // Frame sequencer: state, pointer, counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      count         <= '0;
      ser_load      <= 1'b0;
      ser_data      <= '0;
      ser_bit_valid <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      grant_id      <= '0;
      busy          <= 1'b0;
    end else begin
      ser_load      <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      ser_bit_valid <= (state == SHIFT);
      case (state)
        IDLE: begin
          if (accept_c) begin
            ser_data    <= win_word_c;
            grant_id    <= winner_c;
            rr_ptr      <= (32'(winner_c) == NREQ - 1) ? '0 : IDW'(32'(winner_c) + 1);
            ser_load    <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          count <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (count == CW'(LAST_BIT)) begin
            // final ser_bit_valid lands in the same cycle as this registered pulse
            frame_done <= 1'b1;
            count      <= '0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            count <= count + CW'(1);
          end
        end
        GAP: begin
          if (count == CW'(LAST_GAP)) begin
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
